// File: rtl/lt24_display_pkg.sv
// Shared definitions for the LT24 display path: frame buffer geometry,
// write-arbiter state encoding and requester identities.
package lt24_display_pkg;

    localparam int PIXEL_NUM_DEFAULT = 76800;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT_P = 2'd1;
    localparam logic [1:0] ST_GRANT_O = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        GRANT_P = ST_GRANT_P,
        GRANT_O = ST_GRANT_O
    } arb_state_t;

    // Requester identities, also the encoding of the round-robin owner flag
    localparam logic OWNER_P = 1'b0;
    localparam logic OWNER_O = 1'b1;

endpackage

// File: rtl/counter.sv
// Wrapping up-counter 0..MAX_VALUE-1 with clock enable and synchronous clear.
module counter #(
    parameter  int MAX_VALUE = 16,
    localparam int W         = (MAX_VALUE > 1) ? $clog2(MAX_VALUE) : 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (en) begin
            if (clr)
                r_count <= '0;
            else if (inc)
                r_count <= (r_count == W'(MAX_VALUE - 1)) ? '0 : r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin owner of the frame buffer write port shared by the painter and
// the digit-overlay writer, with burst-length preemption under contention.
module fb_write_arbiter
    import lt24_display_pkg::*;
#(
    parameter int PIXEL_NUM       = PIXEL_NUM_DEFAULT,
    parameter int PIXEL_NUM_WIDTH = $clog2(PIXEL_NUM),
    parameter int MAX_BURST       = 1024
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic                       p_req,
    input  logic                       p_last,
    input  logic                       p_data,
    input  logic [PIXEL_NUM_WIDTH-1:0] p_addr,
    output logic                       p_gnt,
    input  logic                       o_req,
    input  logic                       o_last,
    input  logic                       o_data,
    input  logic [PIXEL_NUM_WIDTH-1:0] o_addr,
    output logic                       o_gnt,
    output logic [PIXEL_NUM_WIDTH-1:0] ram_write_addr,
    output logic                       ram_data,
    output logic                       ram_write_en,
    output logic                       busy
);

    localparam int CNT_MAX = MAX_BURST + 1;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic             r_last_owner;
    logic             w_last_owner_nxt;
    logic             w_beat_p;
    logic             w_beat_o;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_cnt_at_max;
    logic             w_burst_full;
    logic [CNT_W-1:0] w_cnt;

    assign w_beat_p = en & (r_state == GRANT_P) & p_req;
    assign w_beat_o = en & (r_state == GRANT_O) & o_req;

    // Burst is full when the beat in flight brings the count to MAX_BURST
    assign w_cnt_at_max = (w_cnt == CNT_W'(MAX_BURST));
    assign w_burst_full = (w_cnt >= CNT_W'(MAX_BURST - 1));
    assign w_cnt_inc    = (w_beat_p | w_beat_o) & ~w_cnt_at_max;

    counter #(
        .MAX_VALUE (CNT_MAX)
    ) u_beat_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .clr     (w_cnt_clr),
        .inc     (w_cnt_inc),
        .count   (w_cnt)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_last_owner_nxt = r_last_owner;
        w_cnt_clr        = 1'b0;
        if (en) begin
            case (r_state)
                IDLE: begin
                    if (p_req && (!o_req || r_last_owner == OWNER_O))
                        w_state_nxt = GRANT_P;
                    else if (o_req)
                        w_state_nxt = GRANT_O;
                end
                GRANT_P: begin
                    if (!p_req || p_last || (w_burst_full && o_req))
                        w_state_nxt = o_req ? GRANT_O : IDLE;
                end
                GRANT_O: begin
                    if (!o_req || o_last || (w_burst_full && p_req))
                        w_state_nxt = p_req ? GRANT_P : IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
        // Every fresh grant restarts the burst count and records the owner
        if (w_state_nxt != r_state && w_state_nxt != IDLE) begin
            w_cnt_clr        = 1'b1;
            w_last_owner_nxt = (w_state_nxt == GRANT_P) ? OWNER_P : OWNER_O;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_last_owner <= OWNER_O;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_owner_nxt;
        end
    end

    always_comb begin
        ram_write_addr = '0;
        ram_data       = 1'b0;
        case (r_state)
            GRANT_P: begin
                ram_write_addr = p_addr;
                ram_data       = p_data;
            end
            GRANT_O: begin
                ram_write_addr = o_addr;
                ram_data       = o_data;
            end
            default: ;
        endcase
    end

    assign ram_write_en = w_beat_p | w_beat_o;
    assign p_gnt        = (r_state == GRANT_P);
    assign o_gnt        = (r_state == GRANT_O);
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: long burst, contention, preemption,
// clock-enable gating, mid-burst reset and abandon.
module tb_fb_write_arbiter;

    localparam int AW = 17;

    logic          clk;
    logic          reset_n;
    logic          en;
    logic          p_req, p_last, p_data;
    logic [AW-1:0] p_addr;
    logic          p_gnt;
    logic          o_req, o_last, o_data;
    logic [AW-1:0] o_addr;
    logic          o_gnt;
    logic [AW-1:0] ram_write_addr;
    logic          ram_data;
    logic          ram_write_en;
    logic          busy;

    int n_chk  = 0;
    int n_pass = 0;
    int n_wr   = 0;
    int n_viol = 0;

    fb_write_arbiter #(
        .PIXEL_NUM       (76800),
        .PIXEL_NUM_WIDTH (AW),
        .MAX_BURST       (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .en             (en),
        .p_req          (p_req),
        .p_last         (p_last),
        .p_data         (p_data),
        .p_addr         (p_addr),
        .p_gnt          (p_gnt),
        .o_req          (o_req),
        .o_last         (o_last),
        .o_data         (o_data),
        .o_addr         (o_addr),
        .o_gnt          (o_gnt),
        .ram_write_addr (ram_write_addr),
        .ram_data       (ram_data),
        .ram_write_en   (ram_write_en),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Writes land on the next rising edge; inputs are stable at the falling one
    always @(negedge clk) begin
        if (ram_write_en) begin
            n_wr++;
            if (!en) n_viol++;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: run time limit reached, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        p_req = 0; p_last = 0; p_data = 0; p_addr = '0;
        o_req = 0; o_last = 0; o_data = 0; o_addr = '0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        step();
    endtask

    initial begin
        int err, w0, v0, b, cyc;
        reset_n = 0;
        en      = 1;
        clear_inputs();
        #12;
        chk("rst_pgnt", p_gnt, 0);
        chk("rst_ognt", o_gnt, 0);
        chk("rst_we", ram_write_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", ram_write_addr, 0);
        chk("rst_data", ram_data, 0);
        @(negedge clk);
        reset_n = 1;
        step();

        // Full-frame painter burst, overlay silent: saturated counter, no preemption
        p_req = 1; p_addr = '0;
        step();
        chk("t1_gnt", p_gnt, 1);
        w0 = n_wr; err = 0;
        for (int i = 0; i < 76800; i++) begin
            p_addr = AW'(i);
            p_data = i[0] ^ i[4];
            p_last = (i == 76799);
            #1;
            if (!ram_write_en || ram_write_addr != AW'(i) || ram_data != p_data || o_gnt) err++;
            step();
        end
        p_req = 0; p_last = 0;
        chk("t1_beat_err", err, 0);
        chk("t1_writes", n_wr - w0, 76800);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_pgnt", p_gnt, 0);

        // Simultaneous requests after reset: painter first, overlay follows directly
        do_reset();
        p_req = 1; o_req = 1; p_addr = 10; o_addr = 20; p_data = 1; o_data = 0;
        #1;
        chk("t2_idle_we", ram_write_en, 0);
        step();
        chk("t2_pgnt", p_gnt, 1);
        chk("t2_ognt", o_gnt, 0);
        chk("t2_addr", ram_write_addr, 10);
        chk("t2_data", ram_data, 1);
        step();
        p_addr = 11; p_last = 1;
        #1;
        chk("t2_last_we", ram_write_en, 1);
        step();
        p_req = 0; p_last = 0;
        chk("t2_ognt_next", o_gnt, 1);
        chk("t2_busy_no_idle", busy, 1);
        chk("t2_o_addr", ram_write_addr, 20);
        o_last = 1;
        step();
        o_req = 0; o_last = 0;
        chk("t2_end_busy", busy, 0);

        // Preemption at MAX_BURST=4 with painter resuming at its held address
        p_req = 1; p_addr = 100;
        step();
        chk("t3_pgnt", p_gnt, 1);
        err = 0;
        for (int k = 1; k <= 4; k++) begin
            p_addr = AW'(100 + k - 1);
            p_data = k[0];
            if (k == 2) begin o_req = 1; o_addr = 300; o_data = 1; end
            #1;
            if (!ram_write_en || ram_write_addr != AW'(100 + k - 1) || o_gnt) err++;
            step();
        end
        p_addr = 104;
        chk("t3_preempt_ognt", o_gnt, 1);
        chk("t3_preempt_pgnt", p_gnt, 0);
        chk("t3_o_addr", ram_write_addr, 300);
        step();
        o_addr = 301; o_last = 1;
        #1;
        chk("t3_o_last_we", ram_write_en, 1);
        step();
        o_req = 0; o_last = 0;
        chk("t3_regrant_pgnt", p_gnt, 1);
        chk("t3_resume_addr", ram_write_addr, 104);
        for (int k = 5; k <= 10; k++) begin
            p_addr = AW'(100 + k - 1);
            p_last = (k == 10);
            #1;
            if (!ram_write_en || ram_write_addr != AW'(100 + k - 1)) err++;
            step();
        end
        p_req = 0; p_last = 0;
        chk("t3_beat_err", err, 0);
        chk("t3_end_busy", busy, 0);

        // Overlay 8-beat burst with en toggling every cycle
        o_req = 1; o_addr = 200;
        step();
        chk("t4_ognt", o_gnt, 1);
        w0 = n_wr; v0 = n_viol; b = 0; cyc = 0; err = 0;
        while (b < 8 && cyc < 40) begin
            en     = (cyc % 2 == 0);
            o_addr = AW'(200 + b);
            o_data = b[0];
            o_last = (b == 7);
            #1;
            if (ram_write_en != en) err++;
            step();
            if (en) b++;
            cyc++;
        end
        en = 1; o_req = 0; o_last = 0;
        chk("t4_beats", b, 8);
        chk("t4_writes", n_wr - w0, 8);
        chk("t4_en_viol", n_viol - v0, 0);
        chk("t4_we_vs_en", err, 0);
        chk("t4_end_busy", busy, 0);

        // Reset asserted during painter beat 100
        p_req = 1; p_addr = '0;
        step();
        chk("t5_pgnt", p_gnt, 1);
        for (int k = 1; k <= 99; k++) begin
            p_addr = AW'(k - 1);
            step();
        end
        p_addr = 99;
        #1;
        chk("t5_beat100_we", ram_write_en, 1);
        reset_n = 0;
        #1;
        chk("t5_rst_pgnt", p_gnt, 0);
        chk("t5_rst_we", ram_write_en, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_addr", ram_write_addr, 0);
        p_req = 0;
        @(negedge clk);
        reset_n = 1;
        step();
        chk("t5_after_busy", busy, 0);
        chk("t5_after_pgnt", p_gnt, 0);

        // Overlay abandons mid-transfer while painter waits
        o_req = 1; o_addr = 50;
        step();
        chk("t6_ognt", o_gnt, 1);
        step();
        o_req = 0; p_req = 1; p_addr = 60;
        #1;
        chk("t6_gap_we", ram_write_en, 0);
        chk("t6_gap_ognt", o_gnt, 1);
        step();
        chk("t6_pgnt", p_gnt, 1);
        chk("t6_ognt_off", o_gnt, 0);
        chk("t6_p_addr", ram_write_addr, 60);
        p_last = 1;
        step();
        p_req = 0; p_last = 0;
        chk("t6_end_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL have parameter PIXEL_NUM, default 76800, frame buffer depth in pixels.
REQ-002 SHALL have parameter PIXEL_NUM_WIDTH, default $clog2(PIXEL_NUM), write address width.
REQ-003 SHALL have parameter MAX_BURST, default 1024, maximum beats per grant while the other requester waits.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1, clock enable; no state change and no write while low.
REQ-007 SHALL have ports p_req, p_last, p_data, inputs, 1 each: painter write request, final beat of transfer, pixel value.
REQ-008 SHALL have port p_addr, input, PIXEL_NUM_WIDTH, painter write address.
REQ-009 SHALL have port p_gnt, output, 1, painter owns the write port.
REQ-010 SHALL have ports o_req, o_last, o_data, o_addr, inputs (1,1,1,PIXEL_NUM_WIDTH): digit-overlay writer request set, same meaning.
REQ-011 SHALL have port o_gnt, output, 1, overlay owns the write port.
REQ-012 SHALL have ports ram_write_addr (PIXEL_NUM_WIDTH), ram_data (1), ram_write_en (1), outputs to frame buffer.
REQ-013 SHALL have port busy, output, 1, high whenever not IDLE.

Function
REQ-014 States SHALL be IDLE, GRANT_P, GRANT_O; p_gnt high only in GRANT_P, o_gnt high only in GRANT_O (registered, from state).
REQ-015 A beat SHALL occur on a cycle with en && gnt_x && req_x; ram_write_en SHALL equal that term combinationally, ram_addr/ram_data SHALL mux from owner, zero when IDLE.
REQ-016 Requesters SHALL hold req/addr/data stable until a beat; arbiter makes no beat without gnt (zero latency from gnt to write).
REQ-017 IDLE: single requester -> its GRANT state next cycle; both -> requester not equal to last_owner (round-robin); none -> stay.
REQ-018 last_owner SHALL update on every grant entry; reset value = overlay, so painter wins first contention.
REQ-019 GRANT_x exit on beat with last_x: to other GRANT if other req high, else IDLE.
REQ-020 GRANT_x exit when req_x low for one en cycle (abandon): same destination rule as REQ-019.
REQ-021 Beat counter SHALL clear on grant entry, increment per beat, saturate at MAX_BURST.
REQ-022 Counter == MAX_BURST and other req high SHALL preempt after current beat to other GRANT; preempted requester keeps req, is regranted later without losing its address.
REQ-023 Counter == MAX_BURST with other req low: SHALL continue granting without preemption.
REQ-024 en low: state, counter, last_owner SHALL hold; ram_write_en low.
REQ-025 Simultaneous last_x beat and MAX_BURST preempt condition SHALL resolve as REQ-019 (same result).

Reset
REQ-026 reset_n low SHALL asynchronously force IDLE, counter 0, last_owner overlay, p_gnt=o_gnt=ram_write_en=busy=0, ram addr/data 0.
REQ-027 Reset mid-burst SHALL drop the grant immediately; an interrupted transfer is not resumed by the arbiter.
REQ-028 Release of reset_n SHALL be synchronised to clk by the enclosing top level.

Structure
REQ-029 State encoding localparams, PIXEL_NUM default and requester IDs SHALL live in shared package lt24_display_pkg.
REQ-030 Beat counter SHALL be the existing counter sub-module (MAX_VALUE = MAX_BURST+1) with saturation gating in this block; no other sub-modules.

Verification
REQ-031 Painter only, 76800-beat burst, p_last on beat 76800, o_req low -> no preemption, 76800 writes, addr matches p_addr, returns IDLE.
REQ-032 p_req and o_req rise same cycle after reset -> p_gnt first; after p_last, o_gnt next cycle with no IDLE cycle.
REQ-033 MAX_BURST=4, painter 10-beat burst, o_req raised at beat 2 -> overlay granted after painter beat 4; painter resumes at beat 5 address.
REQ-034 en toggled 1/0 during overlay burst of 8 beats -> exactly 8 writes, ram_write_en never high with en low.
REQ-035 reset_n pulsed low during painter beat 100 -> p_gnt, ram_write_en low same cycle, busy 0, IDLE after release.
REQ-036 GRANT_O, o_req drops without o_last, p_req high -> GRANT_P next cycle, no write in between.
